dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the single-cycle CPU core: it is the memory side of the core's `mem_cs`/`mem_rw`/`mem_addr`/`mem_wdata`/`mem_rdata` data port. It holds a word-addressed RAM with combinational read and clocked write, plus a small MMIO window containing a free-running cycle counter, a compare/interrupt flag, an LED register and a sticky error status. It sits beside the instruction memory in the SoC top and serves one access per cycle, with no wait states.

## Interface
- `ADDR_W`, 10: RAM word-index width; depth = 2^ADDR_W words; index = `mem_addr[ADDR_W+1:2]`.
- `MMIO_HI`, 16'hBFAF: value of `mem_addr[31:16]` that selects the MMIO window.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_cs` in 1: access valid this cycle, active high.
- `mem_rw` in 1: 1 = write, 0 = read.
- `mem_addr` in 32: byte address; word accesses only.
- `mem_wdata` in 32: write data.
- `mem_rdata` out 32: read data, combinational.
- `led` out 16: LED register.
- `irq` out 1: compare-match flag (level).

## Operation
- Decode:
  - MMIO when `mem_addr[31:16]==MMIO_HI`; RAM otherwise.
  - Upper RAM address bits above `ADDR_W+1` are ignored, so the RAM aliases.
- RAM:
  - Read: `mem_rdata = ram[index]` when `cs & !rw`.
  - Write: `ram[index] <= mem_wdata` at the edge when `cs & rw`.
  - RAM contents are not reset.
- MMIO offsets (`mem_addr[7:0]`):
  - 0x00 CYCLE (r/w): 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF→0. A write loads `wdata` instead of incrementing.
  - 0x04 LED (r/w): `[15:0]` drives `led`; reads return it zero-extended.
  - 0x08 STATUS: bit0 ERR, bit1 IRQ, other bits read 0. Writing 1 to a bit clears it; writing 0 has no effect.
  - 0x0C CMP (r/w): 32-bit compare value.
  - Any other offset: reads return 0, writes are ignored.
- IRQ set: the flag sets at the edge where CYCLE (current, pre-update value) == CMP. `irq` = the IRQ flag.
- ERR set: the flag sets on any `cs` access with `mem_addr[1:0]!=0`. Such an access is still performed with the low bits ignored.
- `mem_rdata` = 0 when `cs=0` or `rw=1`.
- Simultaneous events:
  - Set and W1C clear of the same STATUS bit in one cycle: set wins.
  - CYCLE write and increment in one cycle: write wins.
  - A CMP write takes effect for the compare starting the next cycle.

## Timing
- Read latency 0: data is valid in the same cycle as the request.
- Write is visible to a read on the next cycle. A read of the same address in the write cycle returns the old value.
- No handshake or stall: every `cs` cycle completes.
- Reset values (asynchronous, on `rst=0`):
  - CYCLE = 0, CMP = 0xFFFFFFFF, LED = 0, ERR = 0, IRQ = 0.
  - Outputs: `led` = 0, `irq` = 0, and `mem_rdata` = 0 while `cs=0`.
- Reset asserted mid-operation: all registers clear immediately. A write in progress at reset is dropped for MMIO registers; RAM is unaffected.
- After release, CYCLE reads 0 in the first cycle and 1 in the next.

## Configuration
- Macro `DMEM_MMIO_EN`.
- Defined: MMIO window, counter, `led` and `irq` are implemented as described above.
- Undefined:
  - All addresses decode to RAM, and `MMIO_HI` is ignored.
  - `led` is tied to 0 and `irq` is tied to 0.
  - No counter logic is present.
  - Misaligned accesses are not flagged.

## Test plan
- RAM write/read: write 0x12345678 to 0x00000010, read the same address next cycle → 0x12345678. A read in the write cycle itself returns the prior value.
- Aliasing and idle output:
  - With `ADDR_W=10`, write 0xA5 to 0x00000000, then read 0x00001000 → 0xA5.
  - `cs=0` → `mem_rdata` = 0.
- Cycle counter:
  - Release reset; read 0xBFAF0000 on cycles 0 and 3 → 0 and 3.
  - Write 0xFFFFFFFE; reads on the next cycles return 0xFFFFFFFE, then 0xFFFFFFFF, then 0x00000000.
- Compare interrupt:
  - Write CMP=20; `irq` rises on the cycle after CYCLE==20 and stays high.
  - A STATUS write of 0x2 clears it. A W1C issued on a match cycle leaves `irq`=1.
- Error flag: read 0x00000006 → STATUS reads 0x1. Writing 0x1 clears it; writing 0x0 does not.
- LED and reset:
  - Write 0xBEEF to 0xBFAF0004 → `led`=0xBEEF.
  - Assert `rst` low asynchronously mid-cycle → `led`=0 and `irq`=0 immediately.
  - RAM data written before reset still reads back after reset.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory side of the core's mem_* port: word RAM with combinational read,
// plus an MMIO window (cycle counter, compare IRQ, LED, sticky status) when DMEM_MMIO_EN is defined.
module dmem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter logic [15:0] MMIO_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_cs,
  input  logic        mem_rw,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic [15:0] led,
  output logic        irq
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [31:0]       ram_r [DEPTH];
  logic [ADDR_W-1:0] index_s;
  logic              mmio_sel_s;
  logic              rd_en_s;
  logic [31:0]       mmio_rdata_s;
  logic              unused_inputs_s;

  // Low address bits and the bits above the RAM index are don't-care for the RAM path.
  assign unused_inputs_s = ^{mem_addr, MMIO_HI, rst};
  assign index_s         = mem_addr[ADDR_W+1:2];
  assign rd_en_s         = mem_cs & ~mem_rw;

  // RAM write port; contents deliberately have no reset
  always_ff @(posedge clk) begin
    if (mem_cs && mem_rw && !mmio_sel_s) begin
      ram_r[index_s] <= mem_wdata;
    end
  end

  // read-data mux: zero whenever no read is in progress
  always_comb begin
    mem_rdata = 32'h0000_0000;
    if (rd_en_s && mmio_sel_s) begin
      mem_rdata = mmio_rdata_s;
    end else if (rd_en_s) begin
      mem_rdata = ram_r[index_s];
    end else begin
      mem_rdata = 32'h0000_0000;
    end
  end

`ifdef DMEM_MMIO_EN
  localparam logic [7:0] OFF_CYCLE  = 8'h00;
  localparam logic [7:0] OFF_LED    = 8'h04;
  localparam logic [7:0] OFF_STATUS = 8'h08;
  localparam logic [7:0] OFF_CMP    = 8'h0C;

  logic [31:0] cycle_r;
  logic [31:0] cmp_r;
  logic [15:0] led_r;
  logic        err_r;
  logic        irq_r;
  logic [7:0]  off_s;
  logic        mmio_wr_s;
  logic        stat_wr_s;
  logic        irq_set_s;
  logic        err_set_s;

  assign mmio_sel_s = (mem_addr[31:16] == MMIO_HI);
  // Misaligned accesses still hit the register their word address names.
  assign off_s      = {mem_addr[7:2], 2'b00};
  assign mmio_wr_s  = mem_cs & mem_rw & mmio_sel_s;
  assign stat_wr_s  = mmio_wr_s & (off_s == OFF_STATUS);
  assign irq_set_s  = (cycle_r == cmp_r);
  assign err_set_s  = mem_cs & (mem_addr[1:0] != 2'b00);

  // MMIO register read mux
  always_comb begin
    mmio_rdata_s = 32'h0000_0000;
    case (off_s)
      OFF_CYCLE:  mmio_rdata_s = cycle_r;
      OFF_LED:    mmio_rdata_s = {16'h0000, led_r};
      OFF_STATUS: mmio_rdata_s = {30'h0000_0000, irq_r, err_r};
      OFF_CMP:    mmio_rdata_s = cmp_r;
      default:    mmio_rdata_s = 32'h0000_0000;
    endcase
  end

  // MMIO registers: a CYCLE write beats the increment, a flag set beats its W1C clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_r <= 32'h0000_0000;
      cmp_r   <= 32'hFFFF_FFFF;
      led_r   <= 16'h0000;
      err_r   <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      if (mmio_wr_s && (off_s == OFF_CYCLE)) begin
        cycle_r <= mem_wdata;
      end else begin
        cycle_r <= cycle_r + 32'd1;
      end
      if (mmio_wr_s && (off_s == OFF_LED)) begin
        led_r <= mem_wdata[15:0];
      end
      if (mmio_wr_s && (off_s == OFF_CMP)) begin
        cmp_r <= mem_wdata;
      end
      err_r <= err_set_s | (err_r & ~(stat_wr_s & mem_wdata[0]));
      irq_r <= irq_set_s | (irq_r & ~(stat_wr_s & mem_wdata[1]));
    end
  end

  assign led = led_r;
  assign irq = irq_r;
`else
  assign mmio_sel_s   = 1'b0;
  assign mmio_rdata_s = 32'h0000_0000;
  assign led          = 16'h0000;
  assign irq          = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected values, a negedge monitor compares.
module tb_dmem_responder;

  localparam logic [31:0] A_CYC  = 32'hBFAF_0000;
  localparam logic [31:0] A_LED  = 32'hBFAF_0004;
  localparam logic [31:0] A_STAT = 32'hBFAF_0008;
  localparam logic [31:0] A_CMP  = 32'hBFAF_000C;

  localparam int S_LED   = 1;
  localparam int S_IRQ   = 2;
  localparam int S_RDATA = 3;

  typedef struct {
    logic [31:0] exp;
    int          sel;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        mem_cs;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [15:0] led;
  logic        irq;

  exp_t rd_q[$];
  exp_t side_q[$];
  int   checks;
  int   errors;

  dmem_responder #(.ADDR_W(10), .MMIO_HI(16'hBFAF)) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_cs   (mem_cs),
    .mem_rw   (mem_rw),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .led      (led),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: read responses pop rd_q, side-output expectations drain side_q
  exp_t        mon_e;
  logic [31:0] mon_act;
  always @(negedge clk) begin
    if (mem_cs && !mem_rw) begin
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: rdata=%h with no expected entry", mem_rdata);
      end else begin
        mon_e = rd_q.pop_front();
        checks++;
        if (mem_rdata !== mon_e.exp) begin
          errors++;
          $display("FAIL %s: actual=%h expected=%h", mon_e.name, mem_rdata, mon_e.exp);
        end
      end
    end
    while (side_q.size() > 0) begin
      mon_e = side_q.pop_front();
      case (mon_e.sel)
        S_LED:   mon_act = {16'h0000, led};
        S_IRQ:   mon_act = {31'h0, irq};
        default: mon_act = mem_rdata;
      endcase
      checks++;
      if (mon_act !== mon_e.exp) begin
        errors++;
        $display("FAIL %s: actual=%h expected=%h", mon_e.name, mon_act, mon_e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic side(input int s, input logic [31:0] x, input string n);
    exp_t t;
    t.exp = x; t.sel = s; t.name = n;
    side_q.push_back(t);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_cs = 1'b1; mem_rw = 1'b1; mem_addr = a; mem_wdata = d;
    step();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] x, input string n);
    exp_t t;
    t.exp = x; t.sel = 0; t.name = n;
    rd_q.push_back(t);
    mem_cs = 1'b1; mem_rw = 1'b0; mem_addr = a;
    step();
  endtask

  task automatic idle();
    mem_cs = 1'b0; mem_rw = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; mem_cs = 1'b0; mem_rw = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    side(S_LED, 32'h0, "led_reset");
    side(S_IRQ, 32'h0, "irq_reset");
    side(S_RDATA, 32'h0, "rdata_idle_reset");
    idle();
    rst = 1'b1;
`ifdef DMEM_MMIO_EN
    rd(A_CYC, 32'd0, "cycle_c0");
    idle(); idle();
    rd(A_CYC, 32'd3, "cycle_c3");
`else
    idle();
`endif

    // RAM write/read, aliasing, idle output
    side(S_RDATA, 32'h0, "rdata_during_write");
    wr(32'h0000_0010, 32'h1234_5678);
    rd(32'h0000_0010, 32'h1234_5678, "ram_rd_after_wr");
    wr(32'h0000_0000, 32'h0000_00A5);
    rd(32'h0000_1000, 32'h0000_00A5, "ram_alias");
    side(S_RDATA, 32'h0, "rdata_cs0");
    idle();
    wr(32'h0000_07FC, 32'hDEAD_BEEF);
    rd(32'h0000_17FC, 32'hDEAD_BEEF, "ram_alias_hi");
    wr(32'h0000_0FFC, 32'h0BAD_F00D);
    rd(32'h0000_0FFC, 32'h0BAD_F00D, "ram_top");
    rd(32'h0000_07FC, 32'hDEAD_BEEF, "ram_no_clobber");
    wr(32'h0000_0004, 32'h0000_1111);

`ifdef DMEM_MMIO_EN
    // counter wrap; reset CMP of all-ones matches at the wrap
    wr(A_CYC, 32'hFFFF_FFFE);
    rd(A_CYC, 32'hFFFF_FFFE, "cycle_load");
    side(S_IRQ, 32'h0, "irq_before_wrap");
    rd(A_CYC, 32'hFFFF_FFFF, "cycle_max");
    side(S_IRQ, 32'h1, "irq_cmp_reset_match");
    rd(A_CYC, 32'h0000_0000, "cycle_wrap");
    wr(A_STAT, 32'h2);
    rd(A_STAT, 32'h0, "status_clr_wrap_irq");

    // compare interrupt
    wr(A_CYC, 32'd10);
    wr(A_CMP, 32'd20);
    repeat (9) idle();
    side(S_IRQ, 32'h0, "irq_on_match_cycle");
    rd(A_CYC, 32'd20, "cycle_at_match");
    side(S_IRQ, 32'h1, "irq_rise");
    idle();
    repeat (3) idle();
    side(S_IRQ, 32'h1, "irq_stays");
    idle();
    wr(A_STAT, 32'h2);
    side(S_IRQ, 32'h0, "irq_w1c_out");
    rd(A_STAT, 32'h0, "status_irq_w1c");

    // W1C on the match cycle: set wins
    wr(A_CYC, 32'd19);
    idle();
    wr(A_STAT, 32'h2);
    side(S_IRQ, 32'h1, "irq_set_wins_out");
    rd(A_STAT, 32'h2, "status_set_wins");
    wr(A_STAT, 32'h2);
    rd(A_STAT, 32'h0, "status_clear2");

    // error flag
    rd(32'h0000_0006, 32'h0000_1111, "misaligned_rd");
    rd(A_STAT, 32'h1, "err_set");
    wr(A_STAT, 32'h0);
    rd(A_STAT, 32'h1, "err_w0_keep");
    wr(A_STAT, 32'h1);
    rd(A_STAT, 32'h0, "err_w1c");

    // unmapped offset and CMP readback
    wr(32'hBFAF_0010, 32'hFFFF_FFFF);
    rd(32'hBFAF_0010, 32'h0, "unmapped_rd");
    rd(A_CMP, 32'd20, "cmp_rd");

    // LED
    wr(A_LED, 32'hFFFF_BEEF);
    side(S_LED, 32'h0000_BEEF, "led_out");
    rd(A_LED, 32'h0000_BEEF, "led_rd");

    // raise irq ahead of the reset
    wr(A_CYC, 32'd20);
    idle();
    side(S_IRQ, 32'h1, "irq_before_rst");
    idle();
`else
    side(S_LED, 32'h0, "led_tied_low");
    side(S_IRQ, 32'h0, "irq_tied_low");
    wr(32'hBFAF_0008, 32'h0000_0055);
    rd(32'h0000_0008, 32'h0000_0055, "nommio_ram_decode");
    rd(32'hBFAF_0004, 32'h0000_1111, "nommio_alias");
    rd(32'h0000_0006, 32'h0000_1111, "nommio_misaligned");
`endif

    // asynchronous reset in the middle of an LED write cycle
    mem_cs = 1'b1; mem_rw = 1'b1; mem_addr = A_LED; mem_wdata = 32'h0000_1234;
    #3;
    rst = 1'b0;
    side(S_LED, 32'h0, "led_async_rst");
    side(S_IRQ, 32'h0, "irq_async_rst");
    @(posedge clk);
    #1;
    mem_cs = 1'b0;
    side(S_RDATA, 32'h0, "rdata_in_rst");
    step();
    rst = 1'b1;
`ifdef DMEM_MMIO_EN
    rd(A_CYC, 32'd0, "cycle_c0_after_rst");
    idle(); idle();
    rd(A_CYC, 32'd3, "cycle_c3_after_rst");
    rd(A_LED, 32'h0, "led_write_dropped");
    rd(A_CMP, 32'hFFFF_FFFF, "cmp_reset");
    rd(A_STAT, 32'h0, "status_reset");
`endif
    rd(32'h0000_0010, 32'h1234_5678, "ram_survives_rst");
    rd(32'h0000_0FFC, 32'h0BAD_F00D, "ram_top_survives_rst");
    idle(); idle();

    checks++;
    if (rd_q.size() != 0 || side_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending rd=%0d side=%0d expected 0", rd_q.size(), side_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
